// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-lite response codes and fetch bridge state encoding
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } bridge_state_t;

endpackage

// File: rtl/fetch_mem_bridge_if.sv
// rtl/fetch_mem_bridge_if.sv - AXI-lite read channel (AR + R) between fetch master and bridge
interface fetch_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PROT_WIDTH = 3,
  parameter int RESP_WIDTH = 2
);

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [PROT_WIDTH-1:0] arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [RESP_WIDTH-1:0] rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/fetch_mem_bridge.sv
// rtl/fetch_mem_bridge.sv - read-only AXI-lite fetch port to word memory, one read outstanding
// Optional address range check enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_mem_bridge
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PROT_WIDTH = 3,
  parameter int                    RESP_WIDTH = 2,
  parameter int                    DATA_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int                    TIMEOUT    = 255,
  localparam int                   MEM_AW     = $clog2(DATA_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  fetch_mem_bridge_if.slave     s_axi,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvld
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bridge_state_t         state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  timed_out;
  logic                  bad_addr;

  assign offset    = s_axi.araddr - BASE_ADDR;
  assign ar_fire   = s_axi.arvalid && s_axi.arready;
  assign r_fire    = s_axi.rvalid && s_axi.rready;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_SPAN = (ADDR_WIDTH + 1)'(4 * DATA_DEPTH);
  logic [ADDR_WIDTH:0] span_off;

  // The extra top bit turns an address below BASE_ADDR into a huge offset.
  assign span_off = {1'b0, s_axi.araddr} - {1'b0, BASE_ADDR};
  assign bad_addr = (s_axi.araddr[1:0] != 2'b00) || (span_off >= MEM_SPAN);
`else
  assign bad_addr = (s_axi.araddr[1:0] != 2'b00);
`endif

  assign mem_wdata = '0;
  assign mem_wen   = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{s_axi.arprot, offset[1:0], offset[ADDR_WIDTH-1:MEM_AW+2]};

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    s_axi.arready  = 1'b0;
    s_axi.rvalid   = 1'b0;
    mem_en         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Held low while RST is asserted so no request is accepted mid-reset.
        s_axi.arready = !RST;
        if (ar_fire) state_nxt = bad_addr ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_en    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvld || timed_out) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        s_axi.rvalid = 1'b1;
        if (r_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_axi.rdata <= '0;
      s_axi.rresp <= '0;
      mem_addr    <= '0;
      wait_cnt    <= '0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (ar_fire) begin
        mem_addr <= offset[MEM_AW+1:2];
        if (bad_addr) begin
          s_axi.rdata <= '0;
          s_axi.rresp <= RESP_WIDTH'(RESP_SLVERR);
        end
      end
      if (state == ST_WAIT) begin
        if (mem_rvld) begin
          s_axi.rdata <= mem_rdata;
          s_axi.rresp <= RESP_WIDTH'(RESP_OKAY);
        end else if (timed_out) begin
          s_axi.rdata <= '0;
          s_axi.rresp <= RESP_WIDTH'(RESP_SLVERR);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_bridge.sv
// tb/tb_fetch_mem_bridge.sv - scoreboard bench for fetch_mem_bridge with a latency-configurable memory
module tb_fetch_mem_bridge;
  import axi_lite_pkg::*;

  localparam int DEPTH = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_mem_bridge_if axi ();

  logic        mem_en, mem_wen, mem_rvld;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  fetch_mem_bridge dut (
    .CLK      (CLK),
    .RST      (RST),
    .s_axi    (axi),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wen  (mem_wen),
    .mem_rdata(mem_rdata),
    .mem_rvld (mem_rvld)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model: responds lat_sel+1 cycles after the mem_en cycle.
  logic [31:0] mem_model [DEPTH];
  logic [7:0]  en_pipe = '0;
  logic [9:0]  addr_pipe [8];
  logic [2:0]  lat_sel = 3'd0;
  logic        rvld_enable = 1'b1;
  logic        inject_rvld = 1'b0;

  always @(posedge CLK) begin
    en_pipe      <= {en_pipe[6:0], mem_en};
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < 8; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_rvld  = (rvld_enable && en_pipe[lat_sel]) || inject_rvld;
  assign mem_rdata = inject_rvld ? 32'hBAD0_BAD0 : mem_model[addr_pipe[lat_sel]];

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          rv_cyc;
  } exp_t;
  exp_t sb_q[$];
  logic prev_pending = 1'b0;
  int   n_resp = 0;

  always @(negedge CLK) begin
    if (!RST && axi.rvalid) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rvalid: rvalid=1 with no outstanding read, required 0");
      end else begin
        if (!prev_pending) check("rvalid_cycle", 32'(cyc), 32'(sb_q[0].rv_cyc));
        check("rdata", axi.rdata, sb_q[0].data);
        check("rresp", 32'(axi.rresp), 32'(sb_q[0].resp));
        if (axi.rready) begin
          void'(sb_q.pop_front());
          n_resp <= n_resp + 1;
        end
      end
    end
    prev_pending <= !RST && axi.rvalid && !axi.rready;
  end

  int         men_count = 0;
  int         men_cyc   = -1;
  logic [9:0] men_addr  = '0;
  always @(negedge CLK) begin
    if (mem_en) begin
      men_count <= men_count + 1;
      men_cyc   <= cyc;
      men_addr  <= mem_addr;
      check("mem_write_tied_off", {mem_wdata[30:0], mem_wen}, 32'h0);
    end
  end

  task automatic read_req(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int delta, output int hs_cyc);
    int t = 0;
    @(posedge CLK); #1;
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    axi.arprot  = 3'b100;
    @(negedge CLK);
    while (!axi.arready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!axi.arready) begin
      n_total++;
      $display("FAIL ar_handshake: arready=0 after 50 cycles, required 1");
    end
    @(posedge CLK); #1;
    hs_cyc      = cyc;
    axi.arvalid = 1'b0;
    sb_q.push_back('{data, resp, hs_cyc + delta});
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (n_resp < target && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("resp_count", 32'(n_resp), 32'(target));
  endtask

  task automatic wait_rvalid(input int budget);
    int t = 0;
    @(negedge CLK);
    while (!axi.rvalid && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("rvalid_seen", 32'(axi.rvalid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    int men_before;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    mem_model[0]    = 32'h0000_0013;
    mem_model[5]    = 32'h0051_0093;
    mem_model[1023] = 32'hDEAD_BEEF;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arprot  = '0;
    axi.rready  = 1'b1;

    repeat (3) @(negedge CLK);
    check("rst_arready", 32'(axi.arready), 32'h0);
    check("rst_rvalid", 32'(axi.rvalid), 32'h0);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_rresp", 32'(axi.rresp), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("arready_after_rst", 32'(axi.arready), 32'h1);

    // Word 0, L=1
    read_req(32'hFFFF_0000, 32'h0000_0013, RESP_OKAY, 2, hs);
    wait_done(1, 20);
    check("t1_mem_en_cycle", 32'(men_cyc), 32'(hs));
    check("t1_mem_addr", 32'(men_addr), 32'd0);
    check("t1_mem_en_count", 32'(men_count), 32'd1);

    // Last word with R back-pressure
    @(posedge CLK); #1;
    axi.rready = 1'b0;
    read_req(32'hFFFF_0FFC, 32'hDEAD_BEEF, RESP_OKAY, 2, hs);
    wait_rvalid(20);
    check("t2_arready_stall", 32'(axi.arready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t2_arready_stall", 32'(axi.arready), 32'h0);
      check("t2_rvalid_stall", 32'(axi.rvalid), 32'h1);
    end
    check("t2_mem_addr", 32'(men_addr), 32'd1023);
    @(posedge CLK); #1;
    axi.rready = 1'b1;
    @(negedge CLK);
    check("t2_arready_at_rready", 32'(axi.arready), 32'h0);
    @(negedge CLK);
    check("t2_arready_after", 32'(axi.arready), 32'h1);
    wait_done(2, 5);

    // Slower memory, L=3
    lat_sel = 3'd2;
    read_req(32'hFFFF_0014, 32'h0051_0093, RESP_OKAY, 4, hs);
    wait_done(3, 20);
    check("t3_mem_addr", 32'(men_addr), 32'd5);
    lat_sel = 3'd0;

    // Reset while waiting for memory aborts the read
    rvld_enable = 1'b0;
    read_req(32'hFFFF_0020, 32'h0, RESP_OKAY, 2, hs);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    sb_q.delete();
    @(negedge CLK);
    check("wrst_arready", 32'(axi.arready), 32'h0);
    check("wrst_rvalid", 32'(axi.rvalid), 32'h0);
    check("wrst_rdata", axi.rdata, 32'h0);
    check("wrst_rresp", 32'(axi.rresp), 32'h0);
    check("wrst_mem_en", 32'(mem_en), 32'h0);
    check("wrst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    rvld_enable = 1'b1;
    inject_rvld = 1'b1;
    @(posedge CLK); #1;
    inject_rvld = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("wrst_no_rvalid", 32'(axi.rvalid), 32'h0);
    end

    // Misaligned address
    men_before = men_count;
    read_req(32'hFFFF_0002, 32'h0, RESP_SLVERR, 0, hs);
    wait_done(4, 10);
    check("t4_no_mem_en", 32'(men_count), 32'(men_before));

    // Memory never answers; late rvld during RESP and IDLE is ignored
    rvld_enable = 1'b0;
    @(posedge CLK); #1;
    axi.rready = 1'b0;
    read_req(32'hFFFF_0010, 32'h0, RESP_SLVERR, 256, hs);
    wait_rvalid(400);
    check("t5_mem_addr", 32'(men_addr), 32'd4);
    @(posedge CLK); #1;
    inject_rvld = 1'b1;
    @(posedge CLK); #1;
    inject_rvld = 1'b0;
    axi.rready  = 1'b1;
    wait_done(5, 10);
    @(posedge CLK); #1;
    inject_rvld = 1'b1;
    @(posedge CLK); #1;
    inject_rvld = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("t5_no_rvalid", 32'(axi.rvalid), 32'h0);
    end
    rvld_enable = 1'b1;

    // Address far below the memory window
    men_before = men_count;
`ifdef FETCH_ADDR_CHECK_EN
    read_req(32'h0000_1000, 32'h0, RESP_SLVERR, 0, hs);
    wait_done(6, 10);
    check("t6_no_mem_en", 32'(men_count), 32'(men_before));
`else
    read_req(32'h0000_1000, 32'h0000_0013, RESP_OKAY, 2, hs);
    wait_done(6, 20);
    check("t6_mem_en_count", 32'(men_count), 32'(men_before + 1));
    check("t6_mem_addr", 32'(men_addr), 32'd0);
`endif

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
